// File: rtl/mem_load_store_unit.sv
// Load/store stage: one access per handshake, bus wait with timeout, load alignment/extension.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses fail with err instead of being aligned.
module mem_load_store_unit #(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] mem_read_data,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 32'd1);

   state_t             state_q;
   logic               req_ready_q;
   logic               mem_valid_q;
   logic               mem_write_q;
   logic [31:0]        mem_addr_q;
   logic [3:0]         mem_wstrb_q;
   logic [31:0]        mem_wdata_q;
   logic               resp_valid_q;
   logic [31:0]        rdata_q;
   logic               err_q;
   logic [2:0]         funct3_q;
   logic [1:0]         off_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic               legal_s;
   logic               abort_s;
   logic               to_hit_s;
   logic [1:0]         off_s;
   logic [3:0]         wstrb_s;
   logic [31:0]        wdata_s;
   logic [7:0]         byte_s;
   logic [15:0]        half_s;
   logic [31:0]        ld_data_d;

   // Decode the incoming request: legality, effective byte offset, strobes and lane replication.
   always_comb begin
      legal_s = 1'b0;
      off_s   = req_addr[1:0];
      wstrb_s = 4'b0000;
      wdata_s = req_wdata;
      case (req_funct3)
         3'b000: begin
            legal_s = 1'b1;
            wstrb_s = 4'b0001 << req_addr[1:0];
            wdata_s = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            legal_s = 1'b1;
            off_s   = {req_addr[1], 1'b0};
            wstrb_s = 4'b0011 << {req_addr[1], 1'b0};
            wdata_s = {2{req_wdata[15:0]}};
         end
         3'b010: begin
            legal_s = 1'b1;
            off_s   = 2'b00;
            wstrb_s = 4'b1111;
         end
         3'b100: begin
            legal_s = ~req_write;
         end
         3'b101: begin
            legal_s = ~req_write;
            off_s   = {req_addr[1], 1'b0};
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misal_s;
   assign misal_s = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign abort_s = ~legal_s | misal_s;
`else
   assign abort_s = ~legal_s;
`endif

   // TIMEOUT of zero disables the abort entirely.
   assign to_hit_s = (TIMEOUT != 32'd0) && (cnt_q == TO_LAST);
   assign cnt_d    = cnt_q + CNT_W'(1);

   // Extract and extend the addressed lane of the returned read word.
   always_comb begin
      case (off_q)
         2'b00:   byte_s = mem_rdata[7:0];
         2'b01:   byte_s = mem_rdata[15:8];
         2'b10:   byte_s = mem_rdata[23:16];
         2'b11:   byte_s = mem_rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      half_s = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_data_d = {{24{byte_s[7]}}, byte_s};
         3'b001:  ld_data_d = {{16{half_s[15]}}, half_s};
         3'b010:  ld_data_d = mem_rdata;
         3'b100:  ld_data_d = {24'h000000, byte_s};
         3'b101:  ld_data_d = {16'h0000, half_s};
         default: ld_data_d = 32'h0000_0000;
      endcase
   end

   // Access sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         mem_valid_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= 32'h0000_0000;
         mem_wstrb_q  <= 4'b0000;
         mem_wdata_q  <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         rdata_q      <= 32'h0000_0000;
         err_q        <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               resp_valid_q <= 1'b0;
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  funct3_q    <= req_funct3;
                  off_q       <= off_s;
                  mem_write_q <= req_write;
                  mem_addr_q  <= {req_addr[31:2], 2'b00};
                  mem_wstrb_q <= req_write ? wstrb_s : 4'b0000;
                  mem_wdata_q <= wdata_s;
                  cnt_q       <= '0;
                  if (abort_s) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     err_q        <= 1'b1;
                     rdata_q      <= 32'h0000_0000;
                  end else begin
                     state_q     <= S_REQ;
                     mem_valid_q <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (to_hit_s) begin
                  state_q      <= S_RESP;
                  mem_valid_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  err_q        <= 1'b1;
                  rdata_q      <= 32'h0000_0000;
               end else if (mem_ready) begin
                  mem_valid_q <= 1'b0;
                  cnt_q       <= cnt_d;
                  if (mem_write_q) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     err_q        <= 1'b0;
                     rdata_q      <= 32'h0000_0000;
                  end else begin
                     state_q <= S_WAIT_R;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_WAIT_R: begin
               if (to_hit_s) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  err_q        <= 1'b1;
                  rdata_q      <= 32'h0000_0000;
               end else if (mem_rvalid) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  err_q        <= 1'b0;
                  rdata_q      <= ld_data_d;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RESP: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
            end
            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               mem_valid_q  <= 1'b0;
               req_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign busy          = ~req_ready_q;
   assign mem_valid     = mem_valid_q;
   assign mem_write     = mem_write_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wstrb     = mem_wstrb_q;
   assign mem_wdata     = mem_wdata_q;
   assign resp_valid    = resp_valid_q;
   assign mem_read_data = rdata_q;
   assign err           = err_q;

endmodule
